// File: rtl/apb_regbank_pkg.sv
// Shared types, default parameters and address decode
// for the APB register bank slave.
package apb_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_DEPTH       = 16;
    localparam int DEF_WAIT_STATES = 0;

    localparam logic [31:0] DEF_ID_VALUE = 32'hA9B0_0001;

    // Register 0 is the read-only ID, so writes to it are errors.
    function automatic logic addr_error(
        input logic [63:0] addr,
        input logic        write,
        input int          depth,
        input int          nbytes
    );
        logic [63:0] span;
        logic [63:0] lane_mask;
        span      = 64'(depth) * 64'(nbytes);
        lane_mask = 64'(nbytes) - 64'd1;
        return (addr >= span)
            || ((addr & lane_mask) != 64'd0)
            || (write && (addr == 64'd0));
    endfunction

endpackage

// File: rtl/apb_regbank_storage.sv
// Register array with per-byte write enables;
// index 0 reads back the constant ID.
module apb_regbank_storage
    import apb_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NBYTES     = DATA_WIDTH / 8,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter logic [DATA_WIDTH-1:0] ID_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [NBYTES-1:0]     wstrb,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (idx != '0)) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wstrb[b]) begin
                    regs[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = (idx == '0) ? ID_VALUE : regs[idx];

endmodule

// File: rtl/apb_regbank_slave.sv
// APB register bank slave: IDLE/SETUP/ACCESS FSM with
// programmable wait states and error decode.
module apb_regbank_slave
    import apb_regbank_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int NBYTES      = DATA_WIDTH / 8,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE =
        DATA_WIDTH'(DEF_ID_VALUE)
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSELx,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [NBYTES-1:0]     PSTRB,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int LANE_W = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(DEPTH);

    apb_state_t            state;
    logic [3:0]            wait_cnt;
    logic                  ready;
    logic                  err;
    logic                  complete;
    logic                  we;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rdata;

    // Ready depends only on state, never on live bus inputs.
    assign ready    = (state == ACCESS) && (wait_cnt == 4'd0);
    assign complete = PSELx && PENABLE && ready;
    assign err      = addr_error(64'(PADDR), PWRITE, DEPTH, NBYTES);
    assign idx      = PADDR[LANE_W +: IDX_W];
    assign we       = complete && PWRITE && !err;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (PSELx && !PENABLE) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    wait_cnt <= 4'(WAIT_STATES);
                end
                ACCESS: begin
                    // Abort on a dropped select/enable, else wait or finish.
                    if (!(PSELx && PENABLE)) begin
                        state <= IDLE;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    apb_regbank_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .NBYTES     (NBYTES),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W),
        .ID_VALUE   (ID_VALUE)
    ) u_storage (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (we),
        .idx   (idx),
        .wstrb (PSTRB),
        .wdata (PWDATA),
        .rdata (rdata)
    );

    assign PREADY  = ready;
    assign PSLVERR = ready && err;
    assign PRDATA  = (ready && !PWRITE && !err) ? rdata : '0;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench for apb_regbank_slave over four wait-state
// configurations: directed scenarios plus random traffic.
module tb_apb_regbank_slave;

    localparam int NU = 4;
    localparam int WS_TAB [NU] = '{0, 3, 4, 2};
    localparam logic [31:0] ID = 32'hA9B0_0001;
    localparam int TIMEOUT = 40;

    typedef struct {
        int          u;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst     [NU];
    logic        psel    [NU];
    logic        pwrite  [NU];
    logic        penable [NU];
    logic        pready  [NU];
    logic        pslverr [NU];
    logic [31:0] paddr   [NU];
    logic [31:0] pwdata  [NU];
    logic [31:0] prdata  [NU];
    logic [3:0]  pstrb   [NU];

    exp_t        sb [$];
    logic [31:0] mdl [NU][16];
    int          vecs = 0;
    int          miss = 0;
    bit          started = 0;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        apb_regbank_slave #(
            .WAIT_STATES (WS_TAB[g])
        ) u_dut (
            .PCLK    (clk),
            .PRESET  (rst[g]),
            .PSELx   (psel[g]),
            .PADDR   (paddr[g]),
            .PWRITE  (pwrite[g]),
            .PSTRB   (pstrb[g]),
            .PWDATA  (pwdata[g]),
            .PENABLE (penable[g]),
            .PRDATA  (prdata[g]),
            .PREADY  (pready[g]),
            .PSLVERR (pslverr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int u,
                       input logic [31:0] act,
                       input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            miss++;
            $display("FAIL %s unit%0d: got %h want %h",
                     nm, u, act, want);
        end
    endtask

    // Error rules for a 16 x 32-bit bank.
    function automatic bit is_bad(input logic [31:0] a, input bit wr);
        return (a >= 32'd64) || (a % 4 != 0) || (wr && a == 32'd0);
    endfunction

    always @(negedge clk) begin
        if (started) begin
            for (int u = 0; u < NU; u++) begin
                exp_t e;
                if (pready[u] && psel[u] && penable[u]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ready", u, 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("unit", u, 32'(u), 32'(e.u));
                        chk("pslverr", u, 32'(pslverr[u]), 32'(e.err));
                        chk("prdata", u, prdata[u], e.rdata);
                    end
                end else if (!pready[u]) begin
                    chk("idle_prdata", u, prdata[u], 32'd0);
                    chk("idle_pslverr", u, 32'(pslverr[u]), 32'd0);
                end
            end
        end
    end

    task automatic xfer(input int u, input bit wr,
                        input logic [31:0] a,
                        input logic [3:0] st,
                        input logic [31:0] d);
        exp_t e;
        int   n;
        int   r;
        bit   done;
        e.u     = u;
        e.err   = is_bad(a, wr);
        e.rdata = 32'd0;
        if (!e.err) begin
            r = int'(a / 4);
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (st[b]) mdl[u][r][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                e.rdata = (r == 0) ? ID : mdl[u][r];
            end
        end
        sb.push_back(e);
        psel[u]    = 1'b1;
        penable[u] = 1'b0;
        pwrite[u]  = wr;
        paddr[u]   = a;
        pstrb[u]   = st;
        pwdata[u]  = d;
        @(posedge clk);
        #1;
        penable[u] = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done && n < TIMEOUT) begin
            @(negedge clk);
            n++;
            done = pready[u];
        end
        chk("latency", u, 32'(n), 32'(2 + WS_TAB[u]));
        if (!done) sb.delete(sb.size() - 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int u, input int k);
        psel[u]    = 1'b0;
        penable[u] = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Enable without a proper setup must leave the slave idle.
    task automatic stray_enable(input int u);
        psel[u]    = 1'b0;
        penable[u] = 1'b1;
        @(posedge clk);
        #1;
        psel[u] = 1'b1;
        @(posedge clk);
        #1;
        idle(u, 1);
    endtask

    task automatic reset_mid_write(input int u);
        bit saw;
        saw        = 1'b0;
        psel[u]    = 1'b1;
        penable[u] = 1'b0;
        pwrite[u]  = 1'b1;
        paddr[u]   = 32'h10;
        pstrb[u]   = 4'hF;
        pwdata[u]  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        penable[u] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            saw |= pready[u];
            @(posedge clk);
            #1;
        end
        rst[u] = 1'b1;
        @(negedge clk);
        saw |= pready[u];
        @(posedge clk);
        #1;
        rst[u]     = 1'b0;
        psel[u]    = 1'b0;
        penable[u] = 1'b0;
        @(negedge clk);
        chk("rst_pready", u, 32'(pready[u]), 32'd0);
        chk("rst_pslverr", u, 32'(pslverr[u]), 32'd0);
        chk("rst_prdata", u, prdata[u], 32'd0);
        chk("rst_no_ready", u, 32'(saw), 32'd0);
        for (int r = 0; r < 16; r++) mdl[u][r] = 32'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic abort_write(input int u);
        psel[u]    = 1'b1;
        penable[u] = 1'b0;
        pwrite[u]  = 1'b1;
        paddr[u]   = 32'h04;
        pstrb[u]   = 4'hF;
        pwdata[u]  = 32'h3;
        @(posedge clk);
        #1;
        penable[u] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        penable[u] = 1'b0;
        @(posedge clk);
        #1;
        idle(u, 2);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 5) return 32'($urandom_range(0, 15)) * 4;
        if (k == 6) return 32'($urandom_range(0, 15)) * 4
                         + 32'($urandom_range(1, 3));
        if (k == 7) return 32'd64 + 32'($urandom_range(0, 1023)) * 4;
        if (k == 8) return 32'd0;
        return $urandom;
    endfunction

    initial begin
        for (int u = 0; u < NU; u++) begin
            rst[u]     = 1'b1;
            psel[u]    = 1'b0;
            penable[u] = 1'b0;
            pwrite[u]  = 1'b0;
            paddr[u]   = 32'd0;
            pstrb[u]   = 4'd0;
            pwdata[u]  = 32'd0;
            for (int r = 0; r < 16; r++) mdl[u][r] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) rst[u] = 1'b0;
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk("init_pready", u, 32'(pready[u]), 32'd0);
            chk("init_pslverr", u, 32'(pslverr[u]), 32'd0);
            chk("init_prdata", u, prdata[u], 32'd0);
        end
        started = 1'b1;
        @(posedge clk);
        #1;

        xfer(0, 1, 32'h04, 4'hF, 32'hDEAD_BEEF);
        xfer(0, 0, 32'h04, 4'hF, 32'h0);
        idle(0, 1);
        xfer(0, 1, 32'h0C, 4'hF, 32'hFFFF_FFFF);
        xfer(0, 1, 32'h0C, 4'b0101, 32'h0);
        xfer(0, 0, 32'h0C, 4'h0, 32'h0);
        xfer(0, 1, 32'h0C, 4'h0, 32'h1234_5678);
        xfer(0, 0, 32'h0C, 4'h0, 32'h0);
        idle(0, 1);
        xfer(0, 1, 32'h40, 4'hF, 32'h5555_5555);
        xfer(0, 0, 32'h06, 4'hF, 32'h0);
        xfer(0, 1, 32'h00, 4'hF, 32'h7777_7777);
        xfer(0, 0, 32'h00, 4'hF, 32'h0);
        stray_enable(0);
        xfer(0, 0, 32'h04, 4'hF, 32'h0);
        idle(0, 1);

        xfer(1, 1, 32'h08, 4'hF, 32'h1122_3344);
        xfer(1, 0, 32'h08, 4'hF, 32'h0);
        idle(1, 1);

        reset_mid_write(2);
        xfer(2, 0, 32'h10, 4'hF, 32'h0);
        idle(2, 1);

        xfer(3, 1, 32'h04, 4'hF, 32'h1);
        xfer(3, 1, 32'h08, 4'hF, 32'h2);
        abort_write(3);
        xfer(3, 0, 32'h04, 4'hF, 32'h0);
        xfer(3, 0, 32'h08, 4'hF, 32'h0);
        idle(3, 1);

        for (int u = 0; u < NU; u++) begin
            for (int i = 0; i < 60; i++) begin
                xfer(u, 1'($urandom_range(0, 1)), rand_addr(),
                     4'($urandom_range(0, 15)), $urandom);
                if ($urandom_range(0, 2) != 0) begin
                    idle(u, $urandom_range(1, 3));
                end
                if ($urandom_range(0, 9) == 0) stray_enable(u);
            end
            idle(u, 1);
            for (int r = 0; r < 16; r++) begin
                xfer(u, 0, 32'(r * 4), 4'h0, 32'h0);
            end
            idle(u, 2);
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", 0, 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miss);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

endmodule
